// File: rtl/regfile_mp_sb.sv
// Multi-port register file (NRD read, 2 write) with busy scoreboard and sequential clear sweep; reads are combinational, writes land on the edge.
// Ready drops for NREG-1 cycles while sweeping; writes, allocations and clears are ignored during that window. Macro REGFILE_BYPASS_EN adds write-to-read bypass.
module regfile_mp_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG),
  parameter int NRD  = 2
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [NRD*AW-1:0]   RS,
  output logic [NRD*XLEN-1:0] RData,
  output logic [NRD-1:0]      RBusy,
  input  logic [1:0]          WrEn,
  input  logic [2*AW-1:0]     WrAddr,
  input  logic [2*XLEN-1:0]   WData,
  input  logic                AllocEn,
  input  logic [AW-1:0]       AllocRd,
  input  logic                Clear,
  output logic                Ready
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state, state_nxt;
  logic [AW-1:0]     cnt, cnt_nxt;
  logic              start;
  logic              idle;
  logic [XLEN-1:0]   regs [NREG];
  logic [NREG-1:0]   busy, busy_nxt;
  logic [AW-1:0]     wa0, wa1;
  logic [XLEN-1:0]   wd0, wd1;
  logic [1:0]        we;
  logic              alloc;
  logic [AW-1:0]     ra [NRD];

  assign wa0  = WrAddr[0 +: AW];
  assign wa1  = WrAddr[AW +: AW];
  assign wd0  = WData[0 +: XLEN];
  assign wd1  = WData[XLEN +: XLEN];
  assign idle = (state == IDLE);

  // A clear request in IDLE pre-empts any write or allocation in the same cycle.
  assign we[0] = WrEn[0] && (wa0 != '0) && idle && !Clear;
  assign we[1] = WrEn[1] && (wa1 != '0) && idle && !Clear;
  assign alloc = AllocEn && (AllocRd != '0) && idle && !Clear;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= AW'(1);
      busy  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      busy  <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    start     = 1'b0;
    Ready     = 1'b0;
    case (state)
      IDLE: begin
        Ready = 1'b1;
        if (Clear) begin
          state_nxt = CLEAR;
          cnt_nxt   = AW'(1);
          start     = 1'b1;
        end
      end
      CLEAR: begin
        cnt_nxt = cnt + AW'(1);
        if (cnt == AW'(NREG-1)) begin
          state_nxt = IDLE;
          cnt_nxt   = AW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Allocation is applied after the write clear so a new producer keeps the bit set.
  always_comb begin
    busy_nxt = busy;
    if (start) begin
      busy_nxt = '0;
    end else begin
      if (we[0]) busy_nxt[wa0] = 1'b0;
      if (we[1]) busy_nxt[wa1] = 1'b0;
      if (alloc) busy_nxt[AllocRd] = 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
    end else if (state == CLEAR) begin
      regs[cnt] <= '0;
    end else begin
      if (we[0]) regs[wa0] <= wd0;
      if (we[1]) regs[wa1] <= wd1;
    end
  end

  always_comb begin
    RData = '0;
    RBusy = '0;
    for (int i = 0; i < NRD; i++) begin
      ra[i] = RS[i*AW +: AW];
      if (!Reset && idle && (ra[i] != '0)) begin
        RData[i*XLEN +: XLEN] = regs[ra[i]];
        RBusy[i]              = busy[ra[i]];
`ifdef REGFILE_BYPASS_EN
        if (we[1] && (wa1 == ra[i])) begin
          RData[i*XLEN +: XLEN] = wd1;
          RBusy[i]              = alloc && (AllocRd == ra[i]);
        end else if (we[0] && (wa0 == ra[i])) begin
          RData[i*XLEN +: XLEN] = wd0;
          RBusy[i]              = alloc && (AllocRd == ra[i]);
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb: reset, writes, port conflict, scoreboard, clear sweep and reset mid-sweep.
module tb_regfile_mp_sb;

  logic        Clk;
  logic        Reset;
  logic [9:0]  RS;
  logic [63:0] RData;
  logic [1:0]  RBusy;
  logic [1:0]  WrEn;
  logic [9:0]  WrAddr;
  logic [63:0] WData;
  logic        AllocEn;
  logic [4:0]  AllocRd;
  logic        Clear;
  logic        Ready;

  int n_chk = 0;
  int n_err = 0;
  int low;
  logic [31:0] orv;
  logic        borv;

  regfile_mp_sb #(.XLEN(32), .NREG(32), .AW(5), .NRD(2)) dut (
    .Clk(Clk), .Reset(Reset), .RS(RS), .RData(RData), .RBusy(RBusy),
    .WrEn(WrEn), .WrAddr(WrAddr), .WData(WData), .AllocEn(AllocEn),
    .AllocRd(AllocRd), .Clear(Clear), .Ready(Ready)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    WrEn = 2'b00; AllocEn = 1'b0; Clear = 1'b0;
  endtask

  task automatic read_all(output logic [31:0] o, output logic b);
    o = '0;
    b = 1'b0;
    for (int r = 0; r < 32; r++) begin
      RS = {5'd0, 5'(r)};
      #1;
      o = o | RData[31:0];
      b = b | RBusy[0];
    end
  endtask

  task automatic sweep_len(output int n);
    n = 0;
    while (!Ready && n < 100) begin
      n++;
      tick();
    end
  endtask

  initial begin
    Reset = 1'b1; RS = '0; WrEn = '0; WrAddr = '0; WData = '0;
    AllocEn = 1'b0; AllocRd = '0; Clear = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    RS = {5'd31, 5'd5};
    #1;
    check("rst_ready", 32'(Ready), 32'd1);
    check("rst_rdata", RData[31:0] | RData[63:32], 32'd0);

    Reset = 1'b0;
    #1;
    check("rar_rd0", RData[31:0], 32'd0);
    check("rar_rd1", RData[63:32], 32'd0);
    check("rar_busy", 32'(RBusy), 32'd0);
    check("rar_ready", 32'(Ready), 32'd1);

    // Single write then read back
    tick();
    WrEn = 2'b01; WrAddr = {5'd0, 5'd3}; WData = {32'd0, 32'hDEADBEEF}; RS = {5'd0, 5'd3};
    #1;
`ifdef REGFILE_BYPASS_EN
    check("wr_same", RData[31:0], 32'hDEADBEEF);
`else
    check("wr_same", RData[31:0], 32'd0);
`endif
    tick();
    idle_inputs();
    #1;
    check("wr_next", RData[31:0], 32'hDEADBEEF);

    WrEn = 2'b01; WrAddr = {5'd0, 5'd0}; WData = {32'd0, 32'h1234}; RS = {5'd3, 5'd0};
    #1;
    check("r0_same", RData[31:0], 32'd0);
    tick();
    idle_inputs();
    #1;
    check("r0_next", RData[31:0], 32'd0);
    check("r3_kept", RData[63:32], 32'hDEADBEEF);

    // Dual write to the same register: port 1 wins
    WrEn = 2'b11; WrAddr = {5'd7, 5'd7}; WData = {32'h22, 32'h11}; RS = {5'd7, 5'd0};
    #1;
`ifdef REGFILE_BYPASS_EN
    check("dual_same", RData[63:32], 32'h22);
`else
    check("dual_same", RData[63:32], 32'd0);
`endif
    tick();
    idle_inputs();
    #1;
    check("dual_next", RData[63:32], 32'h22);

    // Scoreboard
    AllocEn = 1'b1; AllocRd = 5'd9; RS = {5'd0, 5'd9};
    #1;
    check("alloc_same", 32'(RBusy[0]), 32'd0);
    tick();
    idle_inputs();
    #1;
    check("alloc_next", 32'(RBusy[0]), 32'd1);

    WrEn = 2'b01; WrAddr = {5'd0, 5'd9}; WData = {32'd0, 32'h99};
    #1;
`ifdef REGFILE_BYPASS_EN
    check("wrb_same_busy", 32'(RBusy[0]), 32'd0);
    check("wrb_same_data", RData[31:0], 32'h99);
`else
    check("wrb_same_busy", 32'(RBusy[0]), 32'd1);
    check("wrb_same_data", RData[31:0], 32'd0);
`endif
    tick();
    idle_inputs();
    #1;
    check("wrb_next_busy", 32'(RBusy[0]), 32'd0);
    check("wrb_next_data", RData[31:0], 32'h99);

    AllocEn = 1'b1; AllocRd = 5'd9; WrEn = 2'b01; WrAddr = {5'd0, 5'd9}; WData = {32'd0, 32'hAB};
    #1;
`ifdef REGFILE_BYPASS_EN
    check("aw_same_busy", 32'(RBusy[0]), 32'd1);
    check("aw_same_data", RData[31:0], 32'hAB);
`else
    check("aw_same_busy", 32'(RBusy[0]), 32'd0);
    check("aw_same_data", RData[31:0], 32'h99);
`endif
    tick();
    idle_inputs();
    #1;
    check("aw_next_busy", 32'(RBusy[0]), 32'd1);
    check("aw_next_data", RData[31:0], 32'hAB);

    // Clear sweep
    WrEn = 2'b11; WrAddr = {5'd15, 5'd1}; WData = {32'hA5A5A5A5, 32'hA5A5A5A5};
    tick();
    WrEn = 2'b01; WrAddr = {5'd0, 5'd31};
    tick();
    idle_inputs();
    RS = {5'd31, 5'd15};
    #1;
    check("pre_r15", RData[31:0], 32'hA5A5A5A5);
    check("pre_r31", RData[63:32], 32'hA5A5A5A5);

    Clear = 1'b1; WrEn = 2'b01; WrAddr = {5'd0, 5'd20}; WData = {32'd0, 32'h77};
    tick();
    Clear = 1'b0;
    WrEn = 2'b01; WrAddr = {5'd0, 5'd2}; WData = {32'd0, 32'hFFFF};
    AllocEn = 1'b1; AllocRd = 5'd5; RS = {5'd9, 5'd15};
    #1;
    check("sweep_rdata", RData[31:0], 32'd0);
    check("sweep_rbusy", 32'(RBusy), 32'd0);
    sweep_len(low);
    idle_inputs();
    check("sweep_len", 32'(low), 32'd31);
    check("sweep_ready", 32'(Ready), 32'd1);
    read_all(orv, borv);
    check("sweep_zero", orv, 32'd0);
    check("sweep_busy", 32'(borv), 32'd0);

    // Reset in the middle of a sweep
    tick();
    WrEn = 2'b01; WrAddr = {5'd0, 5'd30}; WData = {32'd0, 32'h30};
    tick();
    idle_inputs();
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    repeat (9) tick();
    #1;
    check("mid_busy_ready", 32'(Ready), 32'd0);
    Reset = 1'b1;
    RS = {5'd0, 5'd30};
    #1;
    check("mid_rst_ready", 32'(Ready), 32'd1);
    check("mid_rst_rdata", RData[31:0], 32'd0);
    tick();
    Reset = 1'b0;
    read_all(orv, borv);
    check("mid_rst_zero", orv, 32'd0);
    tick();
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    sweep_len(low);
    check("mid_resweep_len", 32'(low), 32'd31);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised multi-port register file for the next datapath generation.
- Provides NRD read ports and two write ports.
- Includes a per-register busy scoreboard for the hazard unit and a sequential clear engine that zeroes the array without a reset.
- Register 0 is hard-wired to zero. Sits between decode (read/alloc) and writeback (write).

Parameters:
- XLEN, 32, data width in bits
- NREG, 32, number of architectural registers (power of 2, >= 4)
- AW, log2(NREG) = 5, register address width
- NRD, 2, number of read ports (1..4)

Ports:
- Clk  in  1  clock, all state updates on rising edge
- Reset  in  1  asynchronous, active-high reset
- RS  in  NRD*AW  read addresses, port i at bits [i*AW +: AW]
- RData  out  NRD*XLEN  read data, port i at bits [i*XLEN +: XLEN]
- RBusy  out  NRD  busy bit of the register addressed by each read port
- WrEn  in  2  write enables, port 0 and port 1
- WrAddr  in  2*AW  write addresses
- WData  in  2*XLEN  write data
- AllocEn  in  1  mark destination busy (instruction issued)
- AllocRd  in  AW  destination register being allocated
- Clear  in  1  single-cycle request to start a clear sweep
- Ready  out  1  high when IDLE; low while sweeping

Behaviour:
- Reset (async): all registers set to 0, all busy bits set to 0, FSM to IDLE, counter to 1.
- Output values while Reset is asserted: Ready=1, RData=0, RBusy=0.
- Reads: combinational, zero latency.
  - RS=0 returns 0 with RBusy=0.
  - Otherwise returns the stored value, subject to bypass (see Optional Feature).
- Writes: take effect on the rising edge when WrEn[k]=1 and WrAddr[k]!=0. Writes to register 0 are dropped.
  - Both ports addressing the same register in the same cycle: port 1 wins.
  - A write clears that register's busy bit, unless the allocation rule below keeps it set.
- Allocation: AllocEn=1 and AllocRd!=0 sets busy[AllocRd] on the rising edge.
  - Allocation together with a write to the same register in the same cycle: busy stays 1 (the new producer wins); the data is still written.
- FSM states are IDLE and CLEAR.
  - IDLE -> CLEAR when Clear=1. On that edge all busy bits clear, counter=1 and Ready drops the next cycle.
  - In CLEAR, each edge zeroes reg[counter] and increments the counter. After clearing reg[NREG-1], the FSM returns to IDLE.
  - The sweep therefore takes NREG-1 cycles; Ready=1 on the first cycle after the last register is zeroed.
  - In CLEAR, WrEn, AllocEn and Clear are ignored, RData is forced to 0 and RBusy is forced to 0.
  - Clear=1 in IDLE in the same cycle as writes: the writes are dropped, and the sweep starts.
- Reset asserted mid-sweep: immediately IDLE with all state zero.
- Counter is AW bits wide and does not wrap; the IDLE transition fires on counter==NREG-1.

Optional Feature:
- Macro: REGFILE_BYPASS_EN
- Defined:
  - A read whose address matches an active write in the same cycle (nonzero address) returns that write's WData combinationally. If both write ports match, port 1 data is returned.
  - RBusy for a matching read is 0 unless AllocEn targets the same register in that cycle.
- Undefined:
  - Reads return the pre-edge stored value. The new value is visible the cycle after the write.
  - RBusy reflects the stored busy bit only.

Test Plan:
- Read-after-reset: assert Reset, release; read RS0=5, RS1=31 -> RData both 0, RBusy 0, Ready 1.
- Write/read: WrEn=01, WrAddr0=3, WData0=0xDEADBEEF.
  - Next cycle RS0=3 -> 0xDEADBEEF.
  - Write WrAddr0=0, WData0=0x1234 -> RS=0 still reads 0.
- Dual-write conflict and bypass: WrEn=11, both addresses 7, WData0=0x11, WData1=0x22.
  - Next cycle RS=7 reads 0x22.
  - With REGFILE_BYPASS_EN, the same cycle already reads 0x22; without it, the same cycle reads the old value.
- Scoreboard: AllocEn with AllocRd=9 -> next cycle RBusy=1 for RS=9.
  - Write reg 9 -> RBusy=0 after the edge.
  - Alloc and write to reg 9 in the same cycle -> RBusy stays 1 and data is updated.
- Clear sweep: preload reg 1, 15 and 31 with 0xA5A5A5A5, pulse Clear.
  - Ready=0 for exactly 31 cycles; writes issued during the sweep are dropped.
  - Afterwards all registers read 0 and Ready=1.
- Reset mid-sweep: pulse Clear, assert Reset at cycle 10 -> Ready=1 immediately, all registers read 0, and the next Clear starts a full 31-cycle sweep.
